// File: rtl/hub75_rx.sv
// hub75_rx: panel-side HUB75 decoder running in the sysclk domain.
// Registers the HUB75 pins once, edge-detects shift clock and latch, shifts
// rgb0/rgb1 into per-half row shift registers and, on each latch, presents
// the row pair with address, column count, length errors and OE on-time
// through a valid/ready handshake.
// Ports:
//   clk_in, rst_in              system clock, synchronous active-high reset
//   hub75_clk/latch/OE/addr     HUB75 control inputs (OE active-low)
//   hub75_rgb0/rgb1             upper/lower half pixel {r,g,b}
//   row_data0/row_data1         captured rows, column c at [3c+:3]
//   row_addr                    address sampled at latch
//   row_valid/row_ready         output handshake
//   col_count                   shift clocks seen before latch (saturating)
//   short_err/long_err          length errors of the row on the output
//   oe_cycles                   OE-low cycles between previous and this latch
//   drop_cnt                    rows discarded under backpressure (saturating)
module hub75_rx #(
  parameter int  NUM_COLS  = 64,
  parameter int  SCAN_RATE = 32,
  parameter int  OE_CNT_W  = 16,
  localparam int AW = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1,
  localparam int CW = $clog2(NUM_COLS) + 1,
  localparam int DW = NUM_COLS * 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                hub75_clk,
  input  logic                hub75_latch,
  input  logic                hub75_OE,
  input  logic [AW-1:0]       hub75_addr,
  input  logic [2:0]          hub75_rgb0,
  input  logic [2:0]          hub75_rgb1,
  output logic [DW-1:0]       row_data0,
  output logic [DW-1:0]       row_data1,
  output logic [AW-1:0]       row_addr,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [CW-1:0]       col_count,
  output logic                short_err,
  output logic                long_err,
  output logic [OE_CNT_W-1:0] oe_cycles,
  output logic [7:0]          drop_cnt
);

  // input stage
  logic          q1_clk_q, q1_latch_q, q1_oe_q, q2_clk_q, q2_latch_q;
  logic [AW-1:0] q1_addr_q;
  logic [2:0]    q1_rgb0_q, q1_rgb1_q;

  // row accumulation
  logic [DW-1:0]       sh0_q, sh1_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                long_q, long_d;
  logic [OE_CNT_W-1:0] oe_q, oe_d;

  // latch snapshot, consumed one cycle after latch_rise
  logic                cap_q;
  logic [AW-1:0]       cap_addr_q;
  logic [CW-1:0]       cap_cnt_q;
  logic                cap_long_q;
  logic [OE_CNT_W-1:0] cap_oe_q;

  // output registers
  logic [DW-1:0]       data0_q, data1_q;
  logic [AW-1:0]       addr_q;
  logic                valid_q, short_q, olong_q;
  logic [CW-1:0]       ocnt_q;
  logic [OE_CNT_W-1:0] ooe_q;
  logic [7:0]          drop_q;

  logic clk_rise, latch_rise;
  assign clk_rise   = q1_clk_q & ~q2_clk_q;
  assign latch_rise = q1_latch_q & ~q2_latch_q;

  // Next-state counters include the current cycle, so a clk_rise or OE-low
  // cycle coinciding with latch_rise is part of the captured row.
  always_comb begin
    cnt_d  = cnt_q;
    long_d = long_q;
    oe_d   = oe_q;
    if (clk_rise) begin
      if (cnt_q == CW'(NUM_COLS)) long_d = 1'b1;
      else                        cnt_d  = cnt_q + 1'b1;
    end
    if (!q1_oe_q && (oe_q != {OE_CNT_W{1'b1}})) oe_d = oe_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q1_clk_q   <= 1'b0;
      q1_latch_q <= 1'b0;
      q1_oe_q    <= 1'b0;
      q2_clk_q   <= 1'b0;
      q2_latch_q <= 1'b0;
      q1_addr_q  <= '0;
      q1_rgb0_q  <= '0;
      q1_rgb1_q  <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      cnt_q      <= '0;
      long_q     <= 1'b0;
      oe_q       <= '0;
      cap_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_cnt_q  <= '0;
      cap_long_q <= 1'b0;
      cap_oe_q   <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
      olong_q    <= 1'b0;
      ocnt_q     <= '0;
      ooe_q      <= '0;
      drop_q     <= '0;
    end else begin
      q1_clk_q   <= hub75_clk;
      q1_latch_q <= hub75_latch;
      q1_oe_q    <= hub75_OE;
      q1_addr_q  <= hub75_addr;
      q1_rgb0_q  <= hub75_rgb0;
      q1_rgb1_q  <= hub75_rgb1;
      q2_clk_q   <= q1_clk_q;
      q2_latch_q <= q1_latch_q;

      // first-shifted pixel ends up in the highest column
      if (clk_rise) begin
        sh0_q <= {sh0_q[DW-4:0], q1_rgb0_q};
        sh1_q <= {sh1_q[DW-4:0], q1_rgb1_q};
      end

      cap_q <= latch_rise;
      if (latch_rise) begin
        cap_addr_q <= q1_addr_q;
        cap_cnt_q  <= cnt_d;
        cap_long_q <= long_d;
        cap_oe_q   <= oe_d;
        cnt_q      <= '0;
        long_q     <= 1'b0;
        oe_q       <= '0;
      end else begin
        cnt_q  <= cnt_d;
        long_q <= long_d;
        oe_q   <= oe_d;
      end

      // Shift registers are read here, one cycle after latch_rise, so a
      // pixel shifted on the latch cycle is already in place.
      if (cap_q) begin
        if (!valid_q || row_ready) begin
          data0_q <= sh0_q;
          data1_q <= sh1_q;
          addr_q  <= cap_addr_q;
          ocnt_q  <= cap_cnt_q;
          short_q <= (cap_cnt_q < CW'(NUM_COLS));
          olong_q <= cap_long_q;
          ooe_q   <= cap_oe_q;
          valid_q <= 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 1'b1;
        end
      end else if (valid_q && row_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign row_data0 = data0_q;
  assign row_data1 = data1_q;
  assign row_addr  = addr_q;
  assign row_valid = valid_q;
  assign col_count = ocnt_q;
  assign short_err = short_q;
  assign long_err  = olong_q;
  assign oe_cycles = ooe_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_hub75_rx.sv
module tb_hub75_rx;
  localparam int NC = 64;
  localparam int DW = NC * 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          hub75_clk = 1'b0, hub75_latch = 1'b0, hub75_OE = 1'b1;
  logic [4:0]    hub75_addr = '0;
  logic [2:0]    hub75_rgb0 = '0, hub75_rgb1 = '0;
  logic          row_ready = 1'b1;

  logic [DW-1:0] row_data0, row_data1, row_data0_8, row_data1_8;
  logic [4:0]    row_addr, row_addr_8;
  logic          row_valid, row_valid_8;
  logic [6:0]    col_count, col_count_8;
  logic          short_err, long_err, short_err_8, long_err_8;
  logic [15:0]   oe_cycles;
  logic [7:0]    oe_cycles_8;
  logic [7:0]    drop_cnt, drop_cnt_8;

  int passed = 0;
  int total  = 0;

  hub75_rx #(.NUM_COLS(NC), .SCAN_RATE(32), .OE_CNT_W(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch),
    .hub75_OE(hub75_OE), .hub75_addr(hub75_addr), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
    .row_data0(row_data0), .row_data1(row_data1), .row_addr(row_addr), .row_valid(row_valid),
    .row_ready(row_ready), .col_count(col_count), .short_err(short_err), .long_err(long_err),
    .oe_cycles(oe_cycles), .drop_cnt(drop_cnt));

  hub75_rx #(.NUM_COLS(NC), .SCAN_RATE(32), .OE_CNT_W(8)) u_dut8 (
    .clk_in(clk_in), .rst_in(rst_in), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch),
    .hub75_OE(hub75_OE), .hub75_addr(hub75_addr), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
    .row_data0(row_data0_8), .row_data1(row_data1_8), .row_addr(row_addr_8), .row_valid(row_valid_8),
    .row_ready(row_ready), .col_count(col_count_8), .short_err(short_err_8), .long_err(long_err_8),
    .oe_cycles(oe_cycles_8), .drop_cnt(drop_cnt_8));

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  // one pixel: clock low with data, then clock high
  task automatic shift_px(input logic [2:0] r0, input logic [2:0] r1);
    hub75_rgb0 = r0; hub75_rgb1 = r1; hub75_clk = 1'b0; tick();
    hub75_clk = 1'b1; tick();
  endtask

  task automatic shift_pattern(input int n);
    for (int k = 0; k < n; k++) shift_px(3'(k % 8), 3'(7 - k % 8));
  endtask

  task automatic pulse_latch(input logic [4:0] a);
    hub75_clk = 1'b0; hub75_addr = a; hub75_latch = 1'b1; tick();
    hub75_latch = 1'b0; tick();
  endtask

  // returns ticks waited; a missing row counts as a failed comparison
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!row_valid && lat < 20) begin tick(); lat++; end
    total++;
    if (row_valid !== 1'b1) $display("FAIL %s_valid_timeout: row_valid=%b after %0d cycles, required 1", name, row_valid, lat);
    else passed++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; tick(); tick(); rst_in = 1'b0;
    total++; if (row_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", row_valid); else passed++;
    total++; if (col_count !== 7'd0) $display("FAIL reset_col_count: got %0d want 0", col_count); else passed++;
    total++; if (drop_cnt !== 8'd0 || oe_cycles !== 16'd0) $display("FAIL reset_counters: drop=%0d oe=%0d want 0/0", drop_cnt, oe_cycles); else passed++;
    total++; if (row_data0 !== '0 || row_addr !== 5'd0) $display("FAIL reset_data: addr=%0d data0=%h want 0", row_addr, row_data0); else passed++;
  endtask

  task automatic test_nominal();
    int lat;
    row_ready = 1'b1;
    shift_pattern(64);
    pulse_latch(5'd5);
    wait_valid("nominal", lat);
    total++; if (lat !== 1) $display("FAIL nominal_latency: got %0d ticks after latch task, want 1", lat); else passed++;
    total++; if (row_addr !== 5'd5) $display("FAIL nominal_addr: got %0d want 5", row_addr); else passed++;
    total++; if (row_data0[63*3 +: 3] !== 3'd0 || row_data0[0 +: 3] !== 3'd7)
      $display("FAIL nominal_data0: col63=%0d col0=%0d want 0/7", row_data0[63*3 +: 3], row_data0[0 +: 3]); else passed++;
    total++; if (row_data1[63*3 +: 3] !== 3'd7 || row_data1[0 +: 3] !== 3'd0)
      $display("FAIL nominal_data1: col63=%0d col0=%0d want 7/0", row_data1[63*3 +: 3], row_data1[0 +: 3]); else passed++;
    total++; if (col_count !== 7'd64 || short_err !== 1'b0 || long_err !== 1'b0)
      $display("FAIL nominal_count: cnt=%0d short=%b long=%b want 64/0/0", col_count, short_err, long_err); else passed++;
    tick();
    total++; if (row_valid !== 1'b0) $display("FAIL nominal_pulse: valid=%b one cycle after transfer, want 0", row_valid); else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    row_ready = 1'b0;
    shift_pattern(64); pulse_latch(5'd3);
    wait_valid("bp_first", lat);
    shift_pattern(64); pulse_latch(5'd4);
    repeat (4) tick();
    total++; if (row_valid !== 1'b1 || row_addr !== 5'd3) $display("FAIL bp_hold: valid=%b addr=%0d want 1/3", row_valid, row_addr); else passed++;
    total++; if (drop_cnt !== 8'd1) $display("FAIL bp_drop: got %0d want 1", drop_cnt); else passed++;
    row_ready = 1'b1; tick();
    total++; if (row_valid !== 1'b0) $display("FAIL bp_release: valid=%b want 0", row_valid); else passed++;
    repeat (6) tick();
    total++; if (row_valid !== 1'b0 || row_addr !== 5'd3) $display("FAIL bp_no_addr4: valid=%b addr=%0d want 0/3", row_valid, row_addr); else passed++;
  endtask

  task automatic test_length();
    int lat;
    shift_pattern(40); pulse_latch(5'd7);
    wait_valid("short", lat);
    total++; if (short_err !== 1'b1 || long_err !== 1'b0 || col_count !== 7'd40)
      $display("FAIL short_row: short=%b long=%b cnt=%0d want 1/0/40", short_err, long_err, col_count); else passed++;
    tick();
    shift_pattern(70); pulse_latch(5'd8);
    wait_valid("long", lat);
    total++; if (long_err !== 1'b1 || short_err !== 1'b0 || col_count !== 7'd64)
      $display("FAIL long_row: long=%b short=%b cnt=%0d want 1/0/64", long_err, short_err, col_count); else passed++;
    // column c holds pixel 69-c
    total++; if (row_data0[0 +: 3] !== 3'd5 || row_data0[63*3 +: 3] !== 3'd6 || row_data1[63*3 +: 3] !== 3'd1)
      $display("FAIL long_data: d0c0=%0d d0c63=%0d d1c63=%0d want 5/6/1",
               row_data0[0 +: 3], row_data0[63*3 +: 3], row_data1[63*3 +: 3]); else passed++;
    tick();
  endtask

  task automatic test_oe();
    int lat;
    pulse_latch(5'd1);
    wait_valid("oe_first", lat);
    repeat (3) tick();
    hub75_OE = 1'b0; repeat (300) tick();
    hub75_OE = 1'b1; repeat (3) tick();
    pulse_latch(5'd2);
    wait_valid("oe_second", lat);
    total++; if (oe_cycles !== 16'd300) $display("FAIL oe_count: got %0d want 300", oe_cycles); else passed++;
    total++; if (row_valid_8 !== 1'b1 || oe_cycles_8 !== 8'd255) $display("FAIL oe_saturate: valid=%b oe=%0d want 1/255", row_valid_8, oe_cycles_8); else passed++;
    total++; if (col_count !== 7'd0 || short_err !== 1'b1) $display("FAIL zero_shift_row: cnt=%0d short=%b want 0/1", col_count, short_err); else passed++;
    tick();
  endtask

  task automatic test_coincident();
    int lat;
    shift_pattern(63);
    hub75_rgb0 = 3'd2; hub75_rgb1 = 3'd6; hub75_clk = 1'b0; tick();
    hub75_clk = 1'b1; hub75_latch = 1'b1; hub75_addr = 5'd9; tick();
    hub75_clk = 1'b0; hub75_latch = 1'b0; tick();
    wait_valid("coincident", lat);
    total++; if (col_count !== 7'd64 || short_err !== 1'b0 || long_err !== 1'b0)
      $display("FAIL coincident_count: cnt=%0d short=%b long=%b want 64/0/0", col_count, short_err, long_err); else passed++;
    total++; if (row_data0[0 +: 3] !== 3'd2 || row_data1[0 +: 3] !== 3'd6 || row_data0[63*3 +: 3] !== 3'd0)
      $display("FAIL coincident_pixel: d0c0=%0d d1c0=%0d d0c63=%0d want 2/6/0",
               row_data0[0 +: 3], row_data1[0 +: 3], row_data0[63*3 +: 3]); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_row();
    int lat;
    shift_pattern(30);
    hub75_clk = 1'b0; rst_in = 1'b1; tick(); rst_in = 1'b0;
    total++; if (row_valid !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL midrst_clear: valid=%b drop=%0d want 0/0", row_valid, drop_cnt); else passed++;
    shift_pattern(64); pulse_latch(5'd12);
    wait_valid("midrst", lat);
    total++; if (col_count !== 7'd64 || short_err !== 1'b0 || long_err !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL midrst_row: cnt=%0d short=%b long=%b drop=%0d want 64/0/0/0", col_count, short_err, long_err, drop_cnt); else passed++;
    total++; if (row_addr !== 5'd12 || row_data0[63*3 +: 3] !== 3'd0 || row_data0[0 +: 3] !== 3'd7)
      $display("FAIL midrst_data: addr=%0d c63=%0d c0=%0d want 12/0/7", row_addr, row_data0[63*3 +: 3], row_data0[0 +: 3]); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_length();
    test_oe();
    test_coincident();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
